// File: rtl/xvga_pkg.sv
// Shared XVGA (1024x768@60) timing defaults, count widths and the sync bundle type.
package xvga_pkg;

  localparam int unsigned XVGA_H_ACTIVE = 1024;
  localparam int unsigned XVGA_H_FP     = 24;
  localparam int unsigned XVGA_H_SYNC   = 136;
  localparam int unsigned XVGA_H_BP     = 160;
  localparam int unsigned XVGA_V_ACTIVE = 768;
  localparam int unsigned XVGA_V_FP     = 3;
  localparam int unsigned XVGA_V_SYNC   = 6;
  localparam int unsigned XVGA_V_BP     = 29;

  localparam int unsigned XVGA_H_TOTAL  = 1344;
  localparam int unsigned XVGA_V_TOTAL  = 806;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;
  localparam int unsigned FCNT_W = 8;

  // Bit order fixes the 3-bit delay-line word as {hsync, vsync, blank}.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for the {hsync, vsync, blank} bundle; stages reset to all ones.
module sync_delay
  import xvga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  sync_t din,
  output sync_t dout
);

  sync_t stage_q [DEPTH];
  sync_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= SYNC_IDLE;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/xvga_timing.sv
// XVGA raster timing generator: counters, syncs, blank and frame counter, all registered.
// Optional delayed sync copies are built when XVGA_SYNC_DELAY_EN is defined.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = XVGA_H_ACTIVE,
  parameter int unsigned H_FP       = XVGA_H_FP,
  parameter int unsigned H_SYNC     = XVGA_H_SYNC,
  parameter int unsigned H_BP       = XVGA_H_BP,
  parameter int unsigned V_ACTIVE   = XVGA_V_ACTIVE,
  parameter int unsigned V_FP       = XVGA_V_FP,
  parameter int unsigned V_SYNC     = XVGA_V_SYNC,
  parameter int unsigned V_BP       = XVGA_V_BP,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vclock,
  input  logic              reset,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frame_start,
`ifdef XVGA_SYNC_DELAY_EN
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              hsync_d,
  output logic              vsync_d,
  output logic              blank_d
`else
  output logic [FCNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries resolved at elaboration so runtime compares stay at count width.
  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] HA_END   = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_FIRST = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_LAST  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] VA_END   = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] VS_FIRST = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_LAST  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
    $error("xvga_timing: SYNC_DELAY must be in 1..8");
  end
  if (H_TOTAL > (1 << HCNT_W) || V_TOTAL > (1 << VCNT_W)) begin : g_bad_total
    $error("xvga_timing: timing totals exceed counter width");
  end

  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              blk_q, blk_d;
  logic              fs_q, fs_d;
  logic [FCNT_W-1:0] fc_q, fc_d;
  logic              h_wrap;

  // Next counts first; every decode below looks at the next counts so it lands with them.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + HCNT_W'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VCNT_W'(1);
    end
    hs_d  = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vs_d  = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    blk_d = (h_d >= HA_END) || (v_d >= VA_END);
    fs_d  = h_wrap && (v_q == V_LAST);
    fc_d  = fc_q + FCNT_W'(fs_d);
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      blk_q <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      blk_q <= blk_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = blk_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

`ifdef XVGA_SYNC_DELAY_EN
  sync_t dly_in;
  sync_t dly_out;

  assign dly_in = '{hsync: hs_q, vsync: vs_q, blank: blk_q};

  sync_delay #(
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .clk (vclock),
    .rst (reset),
    .din (dly_in),
    .dout(dly_out)
  );

  assign hsync_d = dly_out.hsync;
  assign vsync_d = dly_out.vsync;
  assign blank_d = dly_out.blank;
`endif

endmodule

// File: doc/xvga_timing.md
XVGA_TIMING -- requirements
Module: xvga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 24 / 136 / 160, horizontal porch and sync widths in pixels; line total 1344.
REQ-003 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 3 / 6 / 29, vertical porch and sync widths in lines; frame total 806.
REQ-005 Parameter SYNC_DELAY, default 2, delay in clocks for the delayed sync outputs; legal range 1..8.
REQ-006 vclock  in  1  pixel clock, 65 MHz.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 hcount  out  11  pixel number on the current line, 0..1343.
REQ-009 vcount  out  10  line number, 0..805.
REQ-010 hsync  out  1  horizontal sync, active low.
REQ-011 vsync  out  1  vertical sync, active low.
REQ-012 blank  out  1  high outside the active 1024x768 region.
REQ-013 frame_start  out  1  one-clock pulse at the first pixel of each frame.
REQ-014 frame_cnt  out  8  free-running frame counter.
REQ-015 hsync_d, vsync_d, blank_d  out  1 each  delayed copies; present only with XVGA_SYNC_DELAY_EN.

Function
REQ-016 All outputs SHALL be registered on rising vclock and mutually aligned, so that hsync, vsync and blank describe the pixel at (hcount, vcount) in the same cycle.
REQ-017 hcount SHALL increment by 1 each clock and wrap from 1343 to 0.
REQ-018 vcount SHALL increment by 1 only in the cycle where hcount wraps, and SHALL wrap from 805 to 0 when hcount also wraps.
REQ-019 hsync SHALL be 0 exactly for hcount 1048..1183 and 1 otherwise.
REQ-020 vsync SHALL be 0 exactly for vcount 771..776 and 1 otherwise.
REQ-021 blank SHALL be 1 when hcount >= 1024 or vcount >= 768, and 0 otherwise.
REQ-022 frame_start SHALL be 1 only in the cycle where hcount == 0 and vcount == 0 is reached by wrap-around, and SHALL NOT pulse on the first cycle after reset.
REQ-023 frame_cnt SHALL increment by 1 in the same cycle frame_start is 1, and SHALL wrap from 255 to 0.
REQ-024 Comparisons SHALL use the parameterised boundaries (H_ACTIVE+H_FP, and so on), computed at elaboration time; no runtime arithmetic wider than 11 bits.
REQ-025 All sync and blank decoding SHALL be derived from next-count values, so that there is no one-cycle skew against hcount/vcount.

Reset
REQ-026 While reset is 1, outputs SHALL hold: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_cnt=0.
REQ-027 Reset asserted mid-line or mid-frame SHALL take effect immediately, regardless of vclock.
REQ-028 On the first vclock after reset deasserts, hcount SHALL become 1.
REQ-029 With XVGA_SYNC_DELAY_EN, delay-line stages SHALL reset to hsync_d=1, vsync_d=1, blank_d=1.

Configuration
REQ-030 Macro XVGA_SYNC_DELAY_EN: when defined, hsync_d, vsync_d and blank_d SHALL equal hsync, vsync and blank delayed by exactly SYNC_DELAY clocks. This aligns the syncs with registered pixel-generation stages downstream.
REQ-031 When XVGA_SYNC_DELAY_EN is undefined, the delayed ports and the delay logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package xvga_pkg SHALL hold the default timing constants (H_ACTIVE..V_BP), H_TOTAL=1344, V_TOTAL=806, and the count widths (11, 10).
REQ-033 The delay line SHALL be one sub-module, sync_delay: a width-3, depth-SYNC_DELAY shift register with asynchronous reset value 3'b111.

Verification
REQ-034 Release reset, then run 1344 clocks -> hcount is 0, vcount is 1, frame_start never pulses.
REQ-035 Observe line 0 -> hsync low for exactly 136 clocks starting at hcount 1048; blank rises at hcount 1024.
REQ-036 Run one full frame of 1,083,264 clocks -> exactly one frame_start pulse, at (0,0); frame_cnt goes 0 -> 1; vsync low on vcount 771..776 only.
REQ-037 Run 256 frames -> frame_cnt wraps from 255 to 0 on the 256th pulse.
REQ-038 Assert reset at hcount 700, vcount 400 between clock edges -> outputs reach their reset values before the next edge.
REQ-039 With XVGA_SYNC_DELAY_EN and SYNC_DELAY=2 -> hsync_d first falls at hcount 1050, and blank_d equals blank from two clocks earlier throughout the frame.
